// File: rtl/mar_arbiter.sv
// rtl/mar_arbiter.sv - two-port MAR/memory sequencer; `MAR_ARB_RR_EN selects round-robin ties, default fixed priority
module mar_arbiter #(
    parameter int AW = 8,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [1:0]    req,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [1:0]    wr,
    input  logic [DW-1:0] wdata1,
    output logic [1:0]    gnt,
    output logic [1:0]    done,
    output logic [DW-1:0] rdata,
    output logic          mar_we,
    output logic [AW-1:0] mar_di,
    output logic          mem_we,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, LOAD, ACCESS, RESP} state_t;

    state_t        state_q, state_d;
    logic          sel_q;
    logic          wr_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic [DW-1:0] rdata_q;
    logic          win;
    logic          unused_wr0;

    // Fetch port never writes, so its write flag is deliberately dropped.
    assign unused_wr0 = wr[0];

`ifdef MAR_ARB_RR_EN
    logic last_q;

    // On a tie, the port that did not win last time gets the path.
    always_comb begin
        win = req[1] & (~req[0] | ~last_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= 1'b1;
        end else if (state_q == IDLE && req != 2'b00) begin
            last_q <= win;
        end
    end
`else
    always_comb begin
        win = req[1];
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req != 2'b00) state_d = LOAD;
            LOAD:    state_d = ACCESS;
            ACCESS:  state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Request fields are frozen at grant so the requester may change them mid-flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_q   <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            if (state_q == IDLE && req != 2'b00) begin
                sel_q   <= win;
                wr_q    <= win & wr[1];
                addr_q  <= win ? addr1 : addr0;
                wdata_q <= wdata1;
            end
            if (state_q == ACCESS) begin
                rdata_q <= mem_rdata;
            end
        end
    end

    always_comb begin
        gnt       = 2'b00;
        done      = 2'b00;
        rdata     = '0;
        mar_we    = 1'b0;
        mar_di    = '0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        case (state_q)
            LOAD: begin
                gnt    = {sel_q, ~sel_q};
                mar_we = 1'b1;
                mar_di = addr_q;
            end
            ACCESS: begin
                gnt       = {sel_q, ~sel_q};
                mem_we    = wr_q;
                mem_wdata = wdata_q;
            end
            RESP: begin
                gnt   = {sel_q, ~sel_q};
                done  = {sel_q, ~sel_q};
                rdata = rdata_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mar_arbiter.sv
// tb/tb_mar_arbiter.sv - directed self-checking bench for mar_arbiter with a MAR and memory model
module tb_mar_arbiter;

    logic       clk;
    logic       rst_n;
    logic [1:0] req;
    logic [7:0] addr0, addr1;
    logic [1:0] wr;
    logic [7:0] wdata1;
    logic [1:0] gnt, done;
    logic [7:0] rdata;
    logic       mar_we;
    logic [7:0] mar_di;
    logic       mem_we;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata;

    logic [7:0] mem [256];
    logic [7:0] mar;
    logic       bd_we;
    logic [7:0] bd_addr, bd_data;

    int n_assert = 0;
    int n_fail   = 0;

    mar_arbiter #(.AW(8), .DW(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .addr0     (addr0),
        .addr1     (addr1),
        .wr        (wr),
        .wdata1    (wdata1),
        .gnt       (gnt),
        .done      (done),
        .rdata     (rdata),
        .mar_we    (mar_we),
        .mar_di    (mar_di),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // MAR has no reset; memory writes go to the address the MAR holds.
    always @(posedge clk) begin
        if (mar_we) mar <= mar_di;
        if (mem_we) mem[mar] <= mem_wdata;
        else if (bd_we) mem[bd_addr] <= bd_data;
    end
    assign mem_rdata = mem[mar];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic preload(input logic [7:0] a, input logic [7:0] d);
        bd_addr = a;
        bd_data = d;
        bd_we   = 1'b1;
        step();
        bd_we   = 1'b0;
    endtask

    logic [1:0] exp_done;
    logic [7:0] exp_rdata;

    initial begin
        rst_n = 1'b0; req = 2'b00; wr = 2'b00;
        addr0 = 8'h00; addr1 = 8'h00; wdata1 = 8'h00;
        bd_we = 1'b0; bd_addr = 8'h00; bd_data = 8'h00;

        #12;
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_mar_we", 32'(mar_we), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mar_di", 32'(mar_di), 32'd0);
        chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        chk("rst_rdata", 32'(rdata), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        preload(8'h3C, 8'hA5);
        preload(8'h10, 8'h00);
        preload(8'h20, 8'h77);
        preload(8'h40, 8'h11);

        // single read on port 0
        req = 2'b01; addr0 = 8'h3C;
        step();
        chk("rd_mar_we", 32'(mar_we), 32'd1);
        chk("rd_mar_di", 32'(mar_di), 32'h3C);
        chk("rd_gnt_c1", 32'(gnt), 32'b01);
        step();
        chk("rd_gnt_c2", 32'(gnt), 32'b01);
        chk("rd_mem_we", 32'(mem_we), 32'd0);
        chk("rd_done_c2", 32'(done), 32'd0);
        step();
        chk("rd_done", 32'(done), 32'b01);
        chk("rd_rdata", 32'(rdata), 32'hA5);
        req = 2'b00;
        step();
        chk("rd_idle_gnt", 32'(gnt), 32'd0);
        chk("rd_idle_done", 32'(done), 32'd0);

        // single write on port 1; read data is the pre-write value
        req = 2'b10; wr = 2'b10; addr1 = 8'h10; wdata1 = 8'h5A;
        step();
        chk("wr_mar_we", 32'(mar_we), 32'd1);
        chk("wr_mem_we_c1", 32'(mem_we), 32'd0);
        step();
        chk("wr_mem_we_c2", 32'(mem_we), 32'd1);
        chk("wr_mar_we_c2", 32'(mar_we), 32'd0);
        chk("wr_mem_wdata", 32'(mem_wdata), 32'h5A);
        step();
        chk("wr_mem_we_c3", 32'(mem_we), 32'd0);
        chk("wr_done", 32'(done), 32'b10);
        chk("wr_rdata_prewrite", 32'(rdata), 32'h00);
        req = 2'b00; wr = 2'b00;
        step();
        chk("wr_mem_content", 32'(mem[8'h10]), 32'h5A);

        req = 2'b10; addr1 = 8'h10;
        step(); step(); step();
        chk("rdback_done", 32'(done), 32'b10);
        chk("rdback_rdata", 32'(rdata), 32'h5A);
        req = 2'b00;
        step();

        // wr[0] must be ignored
        req = 2'b01; wr = 2'b01; addr0 = 8'h20; wdata1 = 8'hFF;
        step(); step();
        chk("wr0_mem_we", 32'(mem_we), 32'd0);
        step();
        chk("wr0_done", 32'(done), 32'b01);
        chk("wr0_rdata", 32'(rdata), 32'h77);
        req = 2'b00; wr = 2'b00;
        step();
        chk("wr0_mem_kept", 32'(mem[8'h20]), 32'h77);

        // reset during ACCESS of a write
        req = 2'b10; wr = 2'b10; addr1 = 8'h40; wdata1 = 8'hEE;
        step(); step();
        chk("rstw_mem_we_pre", 32'(mem_we), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rstw_mem_we_async", 32'(mem_we), 32'd0);
        chk("rstw_gnt", 32'(gnt), 32'd0);
        req = 2'b00; wr = 2'b00;
        @(negedge clk);
        rst_n = 1'b1;
        chk("rstw_done", 32'(done), 32'd0);
        chk("rstw_mem_kept", 32'(mem[8'h40]), 32'h11);
        step();
        chk("rstw_idle_done", 32'(done), 32'd0);

        // tie, held requests, starting from fresh reset state
        req = 2'b11; wr = 2'b00; addr0 = 8'h3C; addr1 = 8'h10;
        for (int k = 0; k < 3; k++) begin
`ifdef MAR_ARB_RR_EN
            exp_done  = (k % 2 == 0) ? 2'b01 : 2'b10;
            exp_rdata = (k % 2 == 0) ? 8'hA5 : 8'h5A;
`else
            exp_done  = 2'b10;
            exp_rdata = 8'h5A;
`endif
            step();
            chk($sformatf("tie%0d_gnt_c1", k), 32'(gnt), 32'(exp_done));
            step();
            chk($sformatf("tie%0d_gnt_c2", k), 32'(gnt), 32'(exp_done));
            step();
            chk($sformatf("tie%0d_done", k), 32'(done), 32'(exp_done));
            chk($sformatf("tie%0d_rdata", k), 32'(rdata), 32'(exp_rdata));
            step();
            chk($sformatf("tie%0d_idle_gnt", k), 32'(gnt), 32'd0);
        end
        req = 2'b00;
        step();

        // back-to-back port 0: done every 4 cycles, gnt low only in IDLE
        req = 2'b01; addr0 = 8'h20;
        for (int c = 0; c < 8; c++) begin
            step();
            chk($sformatf("b2b_gnt_c%0d", c), 32'(gnt), (c % 4 == 3) ? 32'd0 : 32'b01);
            chk($sformatf("b2b_done_c%0d", c), 32'(done), (c % 4 == 2) ? 32'b01 : 32'd0);
        end
        req = 2'b00;
        step();
        chk("b2b_end_gnt", 32'(gnt), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
